sig_pass_queue: RTL

SIG_PASS_QUEUE -- requirements
Module: sig_pass_queue

---
 rtl/sig_pass_queue.sv | 113 +++++++++++
 1 files changed

// File: rtl/sig_pass_queue.sv
// sig_pass_queue: circular-buffer FIFO with optional flow-through (FLOW) and
// pipelined enq_ready while full (PIPE). Full and empty are told apart with a
// maybe_full flag, so all DEPTH entries are usable and DEPTH may be any value >= 1.
module sig_pass_queue #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enq_valid,
  output logic                           enq_ready,
  input  logic [WIDTH-1:0]               enq_bits,
  output logic                           deq_valid,
  input  logic                           deq_ready,
  output logic [WIDTH-1:0]               deq_bits,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  // A single-entry queue still needs a 1-bit pointer; it simply never leaves 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
  logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
  logic             maybe_full_q, maybe_full_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             ptr_match;
  logic             empty;
  logic             full;
  logic             do_enq;
  logic             do_deq;
  logic [31:0]      ptr_diff;

  // Advance a pointer by one, wrapping at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status, handshake outputs and the internal fire strobes that move state.
  always_comb begin
    ptr_match = (enq_ptr_q == deq_ptr_q);
    empty     = ptr_match && !maybe_full_q;
    full      = ptr_match && maybe_full_q;
    enq_ready = !full || ((PIPE != 0) && deq_ready);
    deq_valid = !empty || ((FLOW != 0) && enq_valid);
    deq_bits  = mem_q[deq_ptr_q];
    do_enq    = enq_valid && enq_ready;
    do_deq    = deq_valid && deq_ready;
    // When flowing through an empty queue nothing is stored to dequeue; if the
    // consumer takes the payload this cycle it bypasses storage entirely.
    if ((FLOW != 0) && empty) begin
      deq_bits = enq_bits;
      do_deq   = 1'b0;
      if (deq_ready) begin
        do_enq = 1'b0;
      end
    end
  end

  // Pointer and maybe_full next-state; maybe_full only changes on an unbalanced cycle.
  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (do_enq) begin
      enq_ptr_d = ptr_inc(enq_ptr_q);
    end
    if (do_deq) begin
      deq_ptr_d = ptr_inc(deq_ptr_q);
    end
    if (do_enq != do_deq) begin
      maybe_full_d = do_enq;
    end
  end

  // Occupancy: pointer distance modulo DEPTH, with full/empty resolving the tie.
  always_comb begin
    ptr_diff = 32'(enq_ptr_q) + 32'(DEPTH) - 32'(deq_ptr_q);
    if (ptr_diff >= 32'(DEPTH)) begin
      ptr_diff = ptr_diff - 32'(DEPTH);
    end
    count = CW'(ptr_diff);
    if (full) begin
      count = CW'(DEPTH);
    end else if (empty) begin
      count = '0;
    end
  end

  // Control state register; reset discards all entries by clearing the pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // Payload storage write port; contents are never reset, only invalidated.
  always_ff @(posedge clock) begin
    if (!reset && do_enq) begin
      mem_q[enq_ptr_q] <= enq_bits;
    end
  end

endmodule
